// File: rtl/cpu64_obi_pkg.sv
// Shared constants and types for the OBI instruction-memory responder.
package cpu64_obi_pkg;

  localparam int unsigned OBI_DW  = 32;
  localparam int unsigned OBI_BEW = 4;

  // Default word for array preload images (RV addi x0,x0,0).
  localparam logic [31:0] OBI_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } obi_rsp_t;

  // Fibonacci LFSR, taps 16,14,13,11 (bit positions 15,13,12,10).
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/cpu64_obi_rsp_delay_line.sv
// LATENCY-stage response pipe. Payload only advances behind a valid stage, so
// the output payload holds the last delivered response while valid is low.
module cpu64_obi_rsp_delay_line
  import cpu64_obi_pkg::*;
#(
  parameter int unsigned LATENCY = 1
) (
  input  logic     i_clk,
  input  logic     i_rst,
  input  logic     i_valid,
  input  obi_rsp_t i_rsp,
  output logic     o_valid,
  output obi_rsp_t o_rsp
);

  logic [LATENCY-1:0] r_vld;
  obi_rsp_t           r_rsp [LATENCY];

  // Shift valids every cycle; move payload only with its valid.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vld <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) r_rsp[i] <= '0;
    end else begin
      r_vld[0] <= i_valid;
      if (i_valid) r_rsp[0] <= i_rsp;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        if (r_vld[i-1]) r_rsp[i] <= r_rsp[i-1];
      end
    end
  end

  assign o_valid = r_vld[LATENCY-1];
  assign o_rsp   = r_rsp[LATENCY-1];

endmodule

// File: rtl/cpu64_obi_imem_responder.sv
// OBI subordinate memory model behind the fetch stage's imem port.
// Optional: CPU64_OBI_RSP_STALL_INJECT_EN adds LFSR-driven random grant denial
// gated by stall_inject_en_i.
module cpu64_obi_imem_responder
  import cpu64_obi_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 39,
  parameter int unsigned       MEM_AW    = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       LATENCY   = 1,
  parameter int unsigned       MAX_OUT   = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
`ifdef CPU64_OBI_RSP_STALL_INJECT_EN
  input  logic               stall_inject_en_i,
`endif
  input  logic               req_i,
  output logic               gnt_o,
  input  logic [ADDR_W-1:0]  addr_i,
  input  logic               we_i,
  input  logic [OBI_BEW-1:0] be_i,
  input  logic [OBI_DW-1:0]  wdata_i,
  output logic               rvalid_o,
  output logic [OBI_DW-1:0]  rdata_o,
  output logic               err_o
);

  localparam int unsigned       DEPTH     = 1 << MEM_AW;
  localparam int unsigned       CNT_W     = $clog2(MAX_OUT + 1);
  localparam logic [CNT_W-1:0]  MAX_OUT_C = CNT_W'(MAX_OUT);

  logic [OBI_DW-1:0] r_mem [DEPTH];
  logic [CNT_W-1:0]  r_out_cnt;

  logic              w_retire;
  logic              w_gnt_base;
  logic              w_acc;
  logic [ADDR_W-1:0] w_offset;
  logic [MEM_AW-1:0] w_idx;
  logic [MEM_AW-1:0] w_idx_nx;
  logic              w_err;
  obi_rsp_t          w_rsp;
  obi_rsp_t          w_dl_rsp;

  assign w_gnt_base = req_i & ((r_out_cnt < MAX_OUT_C) | w_retire);

`ifdef CPU64_OBI_RSP_STALL_INJECT_EN
  logic [15:0] r_lfsr;

  // Free-running stall LFSR.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_lfsr <= LFSR_SEED;
    else       r_lfsr <= {r_lfsr[14:0], ^(r_lfsr & LFSR_TAPS)};
  end

  assign gnt_o = w_gnt_base & ~(stall_inject_en_i & (r_lfsr[1:0] == 2'b00));
`else
  assign gnt_o = w_gnt_base;
`endif

  assign w_acc    = req_i & gnt_o;
  assign w_offset = addr_i - BASE_ADDR;
  assign w_idx    = w_offset[MEM_AW+1:2];
  assign w_idx_nx = w_idx + MEM_AW'(1);

  // Decode range/alignment errors and build the response sampled at grant.
  always_comb begin
    w_err = |w_offset[ADDR_W-1:MEM_AW+2];
    if (we_i) w_err = w_err | (w_offset[1:0] != 2'b00);
    else      w_err = w_err | (w_offset[1] & (&w_idx));
    w_rsp.err   = w_err;
    w_rsp.rdata = '0;
    if (!we_i && !w_err) begin
      if (w_offset[1]) w_rsp.rdata = {r_mem[w_idx_nx][15:0], r_mem[w_idx][31:16]};
      else             w_rsp.rdata = r_mem[w_idx];
    end
  end

  // Byte-enable write committed at the grant edge; array is never reset.
  always_ff @(posedge clk_i) begin
    if (w_acc && we_i && !w_err) begin
      for (int unsigned b = 0; b < OBI_BEW; b++) begin
        if (be_i[b]) r_mem[w_idx][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  // Outstanding count: +1 on grant, -1 on retire, unchanged when both.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_out_cnt <= '0;
    end else begin
      case ({w_acc, w_retire})
        2'b10:   r_out_cnt <= r_out_cnt + CNT_W'(1);
        2'b01:   r_out_cnt <= r_out_cnt - CNT_W'(1);
        default: r_out_cnt <= r_out_cnt;
      endcase
    end
  end

  cpu64_obi_rsp_delay_line #(
    .LATENCY (LATENCY)
  ) u_delay (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_valid (w_acc),
    .i_rsp   (w_rsp),
    .o_valid (w_retire),
    .o_rsp   (w_dl_rsp)
  );

  assign rvalid_o = w_retire;
  assign rdata_o  = w_dl_rsp.rdata;
  assign err_o    = w_dl_rsp.err;

endmodule

// File: tb/tb_cpu64_obi_imem_responder.sv
// Directed bench for cpu64_obi_imem_responder: three instances cover
// LATENCY/MAX_OUT = 1/1, 3/2 and 4/1.
module tb_cpu64_obi_imem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [38:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;

  logic        req1, gnt1, rv1, err1;
  logic [31:0] rd1;
  logic        req3, gnt3, rv3, err3;
  logic [31:0] rd3;
  logic        req4, gnt4, rv4, err4;
  logic [31:0] rd4;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  always #5 clk = ~clk;

  cpu64_obi_imem_responder #(.LATENCY(1), .MAX_OUT(1)) u_l1 (
    .clk_i(clk), .rst_i(rst), .req_i(req1), .gnt_o(gnt1), .addr_i(addr),
    .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rv1), .rdata_o(rd1), .err_o(err1));

  cpu64_obi_imem_responder #(.LATENCY(3), .MAX_OUT(2)) u_l3 (
    .clk_i(clk), .rst_i(rst), .req_i(req3), .gnt_o(gnt3), .addr_i(addr),
    .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rv3), .rdata_o(rd3), .err_o(err3));

  cpu64_obi_imem_responder #(.LATENCY(4), .MAX_OUT(1)) u_l4 (
    .clk_i(clk), .rst_i(rst), .req_i(req4), .gnt_o(gnt4), .addr_i(addr),
    .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rv4), .rdata_o(rd4), .err_o(err4));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One LATENCY=1 transaction: present, check grant, cross the edge, drop req.
  task automatic xfer1(input string tag, input logic w, input logic [38:0] a,
                       input logic [3:0] b, input logic [31:0] d);
    req1 = 1'b1; we = w; addr = a; be = b; wdata = d;
    #1;
    check_eq({tag, ".gnt"}, 64'(gnt1), 64'd1);
    @(posedge clk); #1;
    req1 = 1'b0; we = 1'b0;
  endtask

  logic exp_gnt3 [12] = '{1,1,0,1,1,0,1,1,0,0,0,0};
  logic exp_rv3  [12] = '{0,0,0,1,1,0,1,1,0,1,1,0};

  initial begin
    rst = 1'b1; req1 = 1'b0; req3 = 1'b0; req4 = 1'b0;
    addr = '0; we = 1'b0; be = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst.rv", {61'd0, rv1, rv3, rv4}, 64'd0);
    check_eq("rst.rd", {rd1, rd4}, 64'd0);
    check_eq("rst.err", {61'd0, err1, err3, err4}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic latency-1 read of a NOP word.
    xfer1("wr_nop", 1'b1, 39'h0, 4'hF, 32'h0000_0013);
    check_eq("wr_nop.rsp", {rv1, err1, rd1}, {2'b10, 32'h0});
    xfer1("rd_nop", 1'b0, 39'h0, 4'h0, 32'h0);
    check_eq("rd_nop.rsp", {rv1, err1, rd1}, {2'b10, 32'h0000_0013});
    #1;
    check_eq("idle.gnt", 64'(gnt1), 64'd0);
    @(posedge clk); #1;
    check_eq("hold.rsp", {rv1, err1, rd1}, {2'b00, 32'h0000_0013});

    // Straddled halfword read, offset[0] ignored.
    xfer1("wr_m4", 1'b1, 39'h10, 4'hF, 32'hAAAA_BBBB);
    xfer1("wr_m5", 1'b1, 39'h14, 4'hF, 32'hCCCC_DDDD);
    xfer1("rd_12", 1'b0, 39'h12, 4'h0, 32'h0);
    check_eq("rd_12.rsp", {rv1, err1, rd1}, {2'b10, 32'hDDDD_AAAA});
    xfer1("rd_13", 1'b0, 39'h13, 4'h0, 32'h0);
    check_eq("rd_13.rsp", {rv1, err1, rd1}, {2'b10, 32'hDDDD_AAAA});

    // Byte-enable write followed immediately by a read of the same word.
    xfer1("wr_m2", 1'b1, 39'h8, 4'hF, 32'h1122_3344);
    xfer1("wr_be", 1'b1, 39'h8, 4'b0101, 32'hFFEE_DDCC);
    xfer1("rd_be", 1'b0, 39'h8, 4'h0, 32'h0);
    check_eq("rd_be.rsp", {rv1, err1, rd1}, {2'b10, 32'h11EE_33CC});

    // Error paths.
    xfer1("rd_oor", 1'b0, 39'h4000, 4'h0, 32'h0);
    check_eq("rd_oor.rsp", {rv1, err1, rd1}, {2'b11, 32'h0});
    xfer1("rd_last", 1'b0, 39'h3FFE, 4'h0, 32'h0);
    check_eq("rd_last.rsp", {rv1, err1, rd1}, {2'b11, 32'h0});
    xfer1("rd_lastw", 1'b0, 39'h3FFC, 4'h0, 32'h0);
    check_eq("rd_lastw.err", {62'd0, rv1, err1}, 64'b10);
    xfer1("wr_mis", 1'b1, 39'h2, 4'hF, 32'hDEAD_BEEF);
    check_eq("wr_mis.rsp", {rv1, err1, rd1}, {2'b11, 32'h0});
    xfer1("rd_m0", 1'b0, 39'h0, 4'h0, 32'h0);
    check_eq("rd_m0.rsp", {rv1, err1, rd1}, {2'b10, 32'h0000_0013});
    xfer1("wr_hi", 1'b1, 39'h4000, 4'hF, 32'hDEAD_BEEF);
    check_eq("wr_hi.rsp", {rv1, err1, rd1}, {2'b11, 32'h0});
    xfer1("rd_m0b", 1'b0, 39'h0, 4'h0, 32'h0);
    check_eq("rd_m0b.rsp", {rv1, err1, rd1}, {2'b10, 32'h0000_0013});

    // LATENCY=3, MAX_OUT=2 with req held for 8 cycles.
    addr = 39'h0; we = 1'b0;
    for (int c = 0; c < 12; c++) begin
      req3 = (c < 8);
      #1;
      check_eq($sformatf("lim.gnt[%0d]", c), 64'(gnt3), 64'(exp_gnt3[c]));
      check_eq($sformatf("lim.rv[%0d]", c), 64'(rv3), 64'(exp_rv3[c]));
      @(posedge clk); #1;
    end
    req3 = 1'b0;

    // LATENCY=4: grant, reset two cycles later, then re-request.
    for (int c = 0; c < 10; c++) begin
      req4 = (c == 0 || c == 1 || c == 3);
      rst  = (c == 2);
      #1;
      check_eq($sformatf("mid.gnt[%0d]", c), 64'(gnt4), 64'(c == 0 || c == 3));
      check_eq($sformatf("mid.rv[%0d]", c), 64'(rv4), 64'(c == 7));
      @(posedge clk); #1;
    end
    req4 = 1'b0; rst = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
